// File: rtl/m68k_bus_responder_pkg.sv
// Shared types and constants for the WM1200 68EC020 local-bus responder.
// Optional bus-error timeout is selected by WM1200_BERR_TIMEOUT_EN in the top.
package wm1200_bus_pkg;

   typedef enum logic [1:0] {
      PORT32   = 2'b00,
      PORT16   = 2'b01,
      PORT8    = 2'b10,
      PORT_OFF = 2'b11
   } port_w_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      WAIT    = 3'd2,
      ACK     = 3'd3,
      RELEASE = 3'd4,
      ARMED   = 3'd5,
      ERR     = 3'd6
   } resp_state_t;

   localparam logic [2:0] FC_CPU_SPACE = 3'b111;

   localparam logic [1:0] DSACK_32   = 2'b00;
   localparam logic [1:0] DSACK_16   = 2'b01;
   localparam logic [1:0] DSACK_8    = 2'b10;
   localparam logic [1:0] DSACK_NONE = 2'b11;

   localparam logic [1:0] SIZE_LONG  = 2'b00;
   localparam logic [1:0] SIZE_BYTE  = 2'b01;
   localparam logic [1:0] SIZE_WORD  = 2'b10;
   localparam logic [1:0] SIZE_3BYTE = 2'b11;

   function automatic logic [1:0] dsack_for_port(input port_w_t port);
      logic [1:0] code;
      case (port)
         PORT32:  code = DSACK_32;
         PORT16:  code = DSACK_16;
         PORT8:   code = DSACK_8;
         default: code = DSACK_NONE;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/m68k_bus_responder_if.sv
// CPU bus and backend handshake signals of the m68k bus responder.
// The responder connects through the slave modport, the CPU/backend side through master.
interface m68k_bus_responder_if #(
   parameter int NUM_REGIONS = 4,
   parameter int ADDR_W      = 24
);
   logic [ADDR_W-1:0]      A;
   logic [2:0]             fc;
   logic                   r_w;
   logic                   as_n;
   logic                   ds_n;
   logic [1:0]             size;
   logic                   bk_ready;
   logic [1:0]             dsack_n;
   logic                   berr_n;
   logic                   d_buff_oe_n;
   logic                   d_buff_dir;
   logic                   bk_req;
   logic [NUM_REGIONS-1:0] bk_sel;
   logic [ADDR_W-1:0]      bk_addr;
   logic                   bk_rw;
   logic [1:0]             bk_size;
   logic                   bk_abort;

   modport master (
      output A, fc, r_w, as_n, ds_n, size, bk_ready,
      input  dsack_n, berr_n, d_buff_oe_n, d_buff_dir,
             bk_req, bk_sel, bk_addr, bk_rw, bk_size, bk_abort
   );

   modport slave (
      input  A, fc, r_w, as_n, ds_n, size, bk_ready,
      output dsack_n, berr_n, d_buff_oe_n, d_buff_dir,
             bk_req, bk_sel, bk_addr, bk_rw, bk_size, bk_abort
   );
endinterface

// File: rtl/m68k_bus_responder_chk.sv
// Protocol checker bound into the responder: data strobe only inside an
// address strobe, and DSACK only ever asserted while acknowledging.
module m68k_bus_responder_chk
   import wm1200_bus_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   input logic        as_s,
   input logic        ds_s,
   input resp_state_t state,
   input logic [1:0]  dsack_n
);
   a_ds_inside_as: assert property (@(posedge clk) disable iff (!rst_n)
      !ds_s |-> !as_s);

   a_dsack_only_in_ack: assert property (@(posedge clk) disable iff (!rst_n)
      (dsack_n != DSACK_NONE) |-> (state == ACK));
endmodule

// File: rtl/m68k_bus_responder_sync_2ff.sv
// Two-flop synchroniser with a configurable reset preset, used for the
// asynchronous 68k strobes.
module sync_2ff #(
   parameter int               WIDTH  = 1,
   parameter logic [WIDTH-1:0] PRESET = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // metastability stage followed by the stable output stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= PRESET;
         sync_r <= PRESET;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;
endmodule

// File: rtl/m68k_bus_responder.sv
// Multi-region 68EC020 bus-cycle terminator with dynamic bus sizing and abort.
// Define WM1200_BERR_TIMEOUT_EN to add the WAIT timeout and bus-error (ERR) path.
module m68k_bus_responder
   import wm1200_bus_pkg::*;
#(
   parameter int NUM_REGIONS    = 4,
   parameter int ADDR_W         = 24,
   parameter int WAIT_W         = 4,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          cpuclk_a,
   input  logic                          rst_n,
   input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_base,
   input  logic [NUM_REGIONS*ADDR_W-1:0] cfg_mask,
   input  logic [NUM_REGIONS*2-1:0]      cfg_port,
   input  logic [NUM_REGIONS*WAIT_W-1:0] cfg_waits,
   m68k_bus_responder_if.slave           bus
);
   logic as_s;
   logic ds_s;

   resp_state_t state_r, next_s;

   logic [ADDR_W-1:0]      addr_r;
   logic [2:0]             fc_r;
   logic                   rw_r;
   logic [1:0]             size_r;
   logic [WAIT_W-1:0]      wait_cnt_r;
   port_w_t                port_r;

   logic [NUM_REGIONS-1:0] match_s;
   logic [NUM_REGIONS-1:0] hit_sel_s;
   logic                   hit_any_s;
   logic [1:0]             hit_port_s;
   logic [WAIT_W-1:0]      hit_waits_s;
   logic                   launch_s;
   logic                   tmo_done_s;

   logic [1:0]             dsack_r, dsack_s;
   logic                   oe_n_r, oe_n_s;
   logic                   dir_r, dir_s;
   logic                   req_r, req_s;
   logic                   abort_r, abort_s;
   logic [NUM_REGIONS-1:0] sel_r, sel_s;
   logic [ADDR_W-1:0]      bk_addr_r;
   logic                   bk_rw_r;
   logic [1:0]             bk_size_r;

   sync_2ff #(.WIDTH(1), .PRESET(1'b1)) u_as_sync (
      .clk(cpuclk_a), .rst_n(rst_n), .d(bus.as_n), .q(as_s)
   );

   sync_2ff #(.WIDTH(1), .PRESET(1'b1)) u_ds_sync (
      .clk(cpuclk_a), .rst_n(rst_n), .d(bus.ds_n), .q(ds_s)
   );

   // region compare; the lowest matching index is isolated as the one-hot select
   always_comb begin
      match_s     = '0;
      hit_port_s  = 2'b00;
      hit_waits_s = '0;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         match_s[i] = ((addr_r & cfg_mask[i*ADDR_W +: ADDR_W]) ==
                       (cfg_base[i*ADDR_W +: ADDR_W] & cfg_mask[i*ADDR_W +: ADDR_W])) &&
                      (port_w_t'(cfg_port[i*2 +: 2]) != PORT_OFF) &&
                      (fc_r != FC_CPU_SPACE);
      end
      hit_sel_s = match_s & (~match_s + NUM_REGIONS'(1));
      hit_any_s = |match_s;
      for (int i = 0; i < NUM_REGIONS; i++) begin
         hit_port_s  = hit_port_s  | ({2{hit_sel_s[i]}} & cfg_port[i*2 +: 2]);
         hit_waits_s = hit_waits_s | ({WAIT_W{hit_sel_s[i]}} & cfg_waits[i*WAIT_W +: WAIT_W]);
      end
   end

`ifdef WM1200_BERR_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_cnt_r;
   logic             berr_r, berr_s;

   assign tmo_done_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1));

   // cycles spent in WAIT since the backend request
   always_ff @(posedge cpuclk_a or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt_r <= '0;
      end else if (launch_s) begin
         tmo_cnt_r <= '0;
      end else if (state_r == WAIT && !tmo_done_s) begin
         tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   assign tmo_done_s = 1'b0;
`endif

   // FSM state register
   always_ff @(posedge cpuclk_a or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // next state and next registered output values
   always_comb begin
      next_s   = state_r;
      launch_s = 1'b0;
      req_s    = 1'b0;
      abort_s  = 1'b0;
      dsack_s  = dsack_r;
      oe_n_s   = oe_n_r;
      dir_s    = dir_r;
      sel_s    = sel_r;
`ifdef WM1200_BERR_TIMEOUT_EN
      berr_s   = berr_r;
`endif
      case (state_r)
         IDLE: begin
            if (!as_s) begin
               next_s = DECODE;
            end else begin
               next_s = IDLE;
            end
         end
         DECODE: begin
            if (hit_any_s) begin
               next_s   = WAIT;
               launch_s = 1'b1;
               req_s    = 1'b1;
               sel_s    = hit_sel_s;
               oe_n_s   = 1'b0;
               dir_s    = rw_r;
            end else begin
               next_s = ARMED;
            end
         end
         WAIT: begin
            // abort outranks a ready backend, and a ready backend outranks timeout
            if (as_s) begin
               next_s  = IDLE;
               abort_s = 1'b1;
               oe_n_s  = 1'b1;
               dir_s   = 1'b0;
               sel_s   = '0;
            end else if (wait_cnt_r == '0 && bus.bk_ready) begin
               next_s  = ACK;
               dsack_s = dsack_for_port(port_r);
            end else if (tmo_done_s) begin
               next_s  = ERR;
               dsack_s = DSACK_NONE;
               oe_n_s  = 1'b1;
               dir_s   = 1'b0;
`ifdef WM1200_BERR_TIMEOUT_EN
               berr_s  = 1'b0;
`endif
            end else begin
               next_s = WAIT;
            end
         end
         ACK: begin
            if (as_s) begin
               next_s  = RELEASE;
               dsack_s = DSACK_NONE;
               oe_n_s  = 1'b1;
               dir_s   = 1'b0;
               sel_s   = '0;
            end else begin
               next_s = ACK;
            end
         end
         RELEASE: begin
            next_s = IDLE;
         end
         ARMED: begin
            if (as_s) begin
               next_s = IDLE;
            end else begin
               next_s = ARMED;
            end
         end
         ERR: begin
            if (as_s) begin
               next_s = IDLE;
               sel_s  = '0;
`ifdef WM1200_BERR_TIMEOUT_EN
               berr_s = 1'b1;
`endif
            end else begin
               next_s = ERR;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   // cycle capture at DECODE entry and wait-state countdown
   always_ff @(posedge cpuclk_a or negedge rst_n) begin
      if (!rst_n) begin
         addr_r     <= '0;
         fc_r       <= 3'b000;
         rw_r       <= 1'b0;
         size_r     <= 2'b00;
         wait_cnt_r <= '0;
         port_r     <= PORT_OFF;
         bk_addr_r  <= '0;
         bk_rw_r    <= 1'b0;
         bk_size_r  <= 2'b00;
      end else begin
         if (state_r == IDLE && !as_s) begin
            addr_r <= bus.A;
            fc_r   <= bus.fc;
            rw_r   <= bus.r_w;
            size_r <= bus.size;
         end
         if (launch_s) begin
            wait_cnt_r <= hit_waits_s;
            port_r     <= port_w_t'(hit_port_s);
            bk_addr_r  <= addr_r;
            bk_rw_r    <= rw_r;
            bk_size_r  <= size_r;
         end else if (state_r == WAIT && wait_cnt_r != '0) begin
            wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
         end
      end
   end

   // registered bus and backend outputs
   always_ff @(posedge cpuclk_a or negedge rst_n) begin
      if (!rst_n) begin
         dsack_r <= DSACK_NONE;
         oe_n_r  <= 1'b1;
         dir_r   <= 1'b0;
         req_r   <= 1'b0;
         abort_r <= 1'b0;
         sel_r   <= '0;
`ifdef WM1200_BERR_TIMEOUT_EN
         berr_r  <= 1'b1;
`endif
      end else begin
         dsack_r <= dsack_s;
         oe_n_r  <= oe_n_s;
         dir_r   <= dir_s;
         req_r   <= req_s;
         abort_r <= abort_s;
         sel_r   <= sel_s;
`ifdef WM1200_BERR_TIMEOUT_EN
         berr_r  <= berr_s;
`endif
      end
   end

   assign bus.dsack_n     = dsack_r;
   assign bus.d_buff_oe_n = oe_n_r;
   assign bus.d_buff_dir  = dir_r;
   assign bus.bk_req      = req_r;
   assign bus.bk_abort    = abort_r;
   assign bus.bk_sel      = sel_r;
   assign bus.bk_addr     = bk_addr_r;
   assign bus.bk_rw       = bk_rw_r;
   assign bus.bk_size     = bk_size_r;
`ifdef WM1200_BERR_TIMEOUT_EN
   assign bus.berr_n      = berr_r;
`else
   assign bus.berr_n      = 1'b1;
`endif

   m68k_bus_responder_chk u_chk (
      .clk     (cpuclk_a),
      .rst_n   (rst_n),
      .as_s    (as_s),
      .ds_s    (ds_s),
      .state   (state_r),
      .dsack_n (dsack_r)
   );
endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: decode table plus timeout, abort and
// reset-during-ACK sequences.
module tb_m68k_bus_responder;
   import wm1200_bus_pkg::*;

   localparam int NR  = 4;
   localparam int AW  = 24;
   localparam int WW  = 4;
   localparam int TMO = 16;

   logic cpuclk_a = 1'b0;
   logic rst_n    = 1'b0;
   logic [NR*AW-1:0] cfg_base;
   logic [NR*AW-1:0] cfg_mask;
   logic [NR*2-1:0]  cfg_port;
   logic [NR*WW-1:0] cfg_waits;

   always #5 cpuclk_a = ~cpuclk_a;

   m68k_bus_responder_if #(.NUM_REGIONS(NR), .ADDR_W(AW)) bus ();

   m68k_bus_responder #(
      .NUM_REGIONS(NR), .ADDR_W(AW), .WAIT_W(WW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .cpuclk_a  (cpuclk_a),
      .rst_n     (rst_n),
      .cfg_base  (cfg_base),
      .cfg_mask  (cfg_mask),
      .cfg_port  (cfg_port),
      .cfg_waits (cfg_waits),
      .bus       (bus.slave)
   );

   typedef struct {
      logic [23:0] addr;
      logic [2:0]  fc;
      logic        rw;
      logic [1:0]  sz;
      logic [7:0]  port;
      logic [15:0] waits;
      logic [3:0]  sel;
      logic [1:0]  dsack;
      int          lat;
   } vec_t;

   localparam logic [7:0]  P_A = 8'b00_10_01_00;
   localparam logic [7:0]  P_B = 8'b00_10_01_11;
   localparam logic [15:0] W_A = 16'h0230;

   vec_t vt [8];
   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge cpuclk_a);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat, nreq, rel;
      logic [3:0] sel_req;
      logic       dir_req, oe_req;
      logic [1:0] dsk;
      cfg_port  = v.port;
      cfg_waits = v.waits;
      bus.A     = v.addr;
      bus.fc    = v.fc;
      bus.r_w   = v.rw;
      bus.size  = v.sz;
      tick();
      bus.as_n = 1'b0;
      bus.ds_n = 1'b0;
      lat = 0; nreq = 0; sel_req = 4'h0; dir_req = 1'b0; oe_req = 1'b1; dsk = 2'b11;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
         tick();
         if (bus.bk_req) begin
            nreq++;
            sel_req = bus.bk_sel;
            dir_req = bus.d_buff_dir;
            oe_req  = bus.d_buff_oe_n;
         end
         if (bus.dsack_n != 2'b11) begin
            lat = k;
            dsk = bus.dsack_n;
         end
      end
      check($sformatf("v%0d latency", idx), lat, v.lat);
      check($sformatf("v%0d bk_req pulses", idx), nreq, (v.lat != 0) ? 1 : 0);
      if (v.lat != 0) begin
         check($sformatf("v%0d bk_sel", idx), sel_req, v.sel);
         check($sformatf("v%0d dsack_n", idx), dsk, v.dsack);
         check($sformatf("v%0d d_buff_dir", idx), dir_req, v.rw);
         check($sformatf("v%0d d_buff_oe_n", idx), oe_req, 1'b0);
         check($sformatf("v%0d bk_addr", idx), bus.bk_addr, v.addr);
         check($sformatf("v%0d bk_rw", idx), bus.bk_rw, v.rw);
         check($sformatf("v%0d bk_size", idx), bus.bk_size, v.sz);
      end else begin
         check($sformatf("v%0d idle bk_sel", idx), bus.bk_sel, 4'h0);
         check($sformatf("v%0d idle oe_n", idx), bus.d_buff_oe_n, 1'b1);
      end
      bus.as_n = 1'b1;
      bus.ds_n = 1'b1;
      if (v.lat != 0) begin
         rel = 0;
         for (int k = 1; k <= 6 && rel == 0; k++) begin
            tick();
            if (bus.dsack_n == 2'b11) rel = k;
         end
         check($sformatf("v%0d release edges", idx), rel, 3);
         check($sformatf("v%0d release oe_n", idx), bus.d_buff_oe_n, 1'b1);
         check($sformatf("v%0d release bk_sel", idx), bus.bk_sel, 4'h0);
      end
      repeat (4) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int lat, nab, nack;
      cfg_base  = {24'h800000, 24'h400000, 24'h200000, 24'h200000};
      cfg_mask  = {24'h800000, 24'hF00000, 24'hFF0000, 24'hF00000};
      cfg_port  = P_A;
      cfg_waits = W_A;
      bus.A = 24'h0; bus.fc = 3'b101; bus.r_w = 1'b1; bus.size = 2'b00;
      bus.as_n = 1'b1; bus.ds_n = 1'b1; bus.bk_ready = 1'b1;

      vt[0] = '{24'h200010, 3'b101, 1'b1, 2'b00, P_A,   W_A, 4'b0001, 2'b00, 5};
      vt[1] = '{24'h200010, 3'b101, 1'b1, 2'b10, P_B,   W_A, 4'b0010, 2'b01, 8};
      vt[2] = '{24'h400004, 3'b101, 1'b0, 2'b01, P_A,   W_A, 4'b0100, 2'b10, 7};
      vt[3] = '{24'h000000, 3'b101, 1'b1, 2'b00, P_A,   W_A, 4'b0000, 2'b11, 0};
      vt[4] = '{24'h200010, 3'b111, 1'b1, 2'b00, P_A,   W_A, 4'b0000, 2'b11, 0};
      vt[5] = '{24'h912345, 3'b110, 1'b0, 2'b11, P_A,   W_A, 4'b1000, 2'b00, 5};
      vt[6] = '{24'h212345, 3'b101, 1'b1, 2'b00, P_B,   W_A, 4'b0000, 2'b11, 0};
      vt[7] = '{24'h200010, 3'b101, 1'b1, 2'b00, 8'hFF, W_A, 4'b0000, 2'b11, 0};

      #23;
      check("reset dsack_n", bus.dsack_n, 2'b11);
      check("reset berr_n", bus.berr_n, 1'b1);
      check("reset oe_n", bus.d_buff_oe_n, 1'b1);
      check("reset dir", bus.d_buff_dir, 1'b0);
      check("reset bk_req", bus.bk_req, 1'b0);
      check("reset bk_abort", bus.bk_abort, 1'b0);
      check("reset bk_sel", bus.bk_sel, 4'h0);
      check("reset bk_addr", bus.bk_addr, 24'h0);
      check("reset bk_rw", bus.bk_rw, 1'b0);
      check("reset bk_size", bus.bk_size, 2'b00);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      for (int i = 0; i < 8; i++) run_vec(vt[i], i);

      // backend never ready
      cfg_port = P_A; cfg_waits = W_A; bus.A = 24'h200010; bus.r_w = 1'b1; bus.fc = 3'b101;
      bus.bk_ready = 1'b0;
      tick();
      bus.as_n = 1'b0; bus.ds_n = 1'b0;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         tick();
         if (bus.berr_n == 1'b0) lat = k;
      end
`ifdef WM1200_BERR_TIMEOUT_EN
      check("timeout berr edge", lat, 20);
      check("timeout dsack_n", bus.dsack_n, 2'b11);
      check("timeout oe_n", bus.d_buff_oe_n, 1'b1);
      bus.as_n = 1'b1; bus.ds_n = 1'b1;
      lat = 0;
      for (int k = 1; k <= 6 && lat == 0; k++) begin
         tick();
         if (bus.berr_n == 1'b1) lat = k;
      end
      check("timeout berr release", lat, 3);
`else
      check("no-timeout berr never", lat, 0);
      check("no-timeout dsack_n", bus.dsack_n, 2'b11);
      check("no-timeout still waiting oe_n", bus.d_buff_oe_n, 1'b0);
      bus.as_n = 1'b1; bus.ds_n = 1'b1;
      nab = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (bus.bk_abort) nab++;
      end
      check("no-timeout abort on release", nab, 1);
`endif
      bus.bk_ready = 1'b1;
      repeat (4) tick();

      // as_n negated in the middle of a 10 wait-state cycle
      cfg_waits = 16'h023A;
      tick();
      bus.as_n = 1'b0; bus.ds_n = 1'b0;
      repeat (6) tick();
      check("abort pre oe_n", bus.d_buff_oe_n, 1'b0);
      check("abort pre dsack_n", bus.dsack_n, 2'b11);
      bus.as_n = 1'b1; bus.ds_n = 1'b1;
      nab = 0; nack = 0;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (bus.bk_abort) nab++;
         if (bus.dsack_n != 2'b11) nack++;
      end
      check("abort pulses", nab, 1);
      check("abort no dsack", nack, 0);
      check("abort oe_n", bus.d_buff_oe_n, 1'b1);
      check("abort bk_sel", bus.bk_sel, 4'h0);
      repeat (2) tick();

      // reset asserted while acknowledging
      cfg_waits = W_A;
      tick();
      bus.as_n = 1'b0; bus.ds_n = 1'b0;
      repeat (6) tick();
      check("pre-reset dsack_n", bus.dsack_n, 2'b00);
      #2 rst_n = 1'b0;
      #1;
      check("async reset dsack_n", bus.dsack_n, 2'b11);
      check("async reset oe_n", bus.d_buff_oe_n, 1'b1);
      check("async reset bk_sel", bus.bk_sel, 4'h0);
      bus.as_n = 1'b1; bus.ds_n = 1'b1;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      run_vec(vt[0], 8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
